// File: rtl/watch_pkg.sv
// Shared watch encodings: display mode and edit position, used by the
// switch controller, the counters and the display mux.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'b00,
    MODE_SETUP = 2'b01,
    MODE_ALARM = 2'b10,
    MODE_TIMER = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC = 2'b00,
    POS_MIN = 2'b01,
    POS_HOU = 2'b10
  } pos_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK: next_mode = MODE_SETUP;
      MODE_SETUP: next_mode = MODE_ALARM;
      MODE_ALARM: next_mode = MODE_TIMER;
      default:    next_mode = MODE_CLOCK;
    endcase
  endfunction

  // HOU wraps to SEC; the unused 2'b11 code also recovers to SEC.
  function automatic pos_e next_pos(input pos_e p);
    case (p)
      POS_SEC: next_pos = POS_MIN;
      POS_MIN: next_pos = POS_HOU;
      default: next_pos = POS_SEC;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One push-button: 2-FF synchroniser, debounce counter and a registered
// one-cycle pulse on each accepted 0->1 transition.
module sw_debounce #(
  parameter int DEB_CNT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CNT + 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // The flip happens on the cycle the count would reach DEB_CNT, so the
  // press pulse is already registered when the controller samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q  <= {sync_q[0], i_raw};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CW'(DEB_CNT - 1)) begin
        stable_q <= sync_q[1];
        press_q  <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign o_level = stable_q;
  assign o_press = press_q;

endmodule

// File: rtl/sw_mode_ctrl.sv
// Watch switch controller: debounces four buttons and sequences mode, edit
// position, increment pulses, alarm arm, stopwatch run/clear and idle return.
module sw_mode_ctrl
  import watch_pkg::*;
#(
  parameter int          DEB_CNT      = 500000,
  parameter logic [31:0] IDLE_TIMEOUT = 32'd1500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_sw,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_incr,
  output logic       o_alarm_en,
  output logic       o_timer_run,
  output logic       o_timer_clr
);

  logic [3:0] press;
  logic [3:0] level_unused;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (i_sw[g]),
      .o_level(level_unused[g]),
      .o_press(press[g])
    );
  end

  mode_e       mode_q;
  pos_e        pos_q;
  logic        incr_q, clr_q, alarm_q, run_q;
  logic [31:0] idle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_CLOCK;
      pos_q   <= POS_SEC;
      incr_q  <= 1'b0;
      clr_q   <= 1'b0;
      alarm_q <= 1'b0;
      run_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      incr_q <= 1'b0;
      clr_q  <= 1'b0;
      if (press[3]) alarm_q <= ~alarm_q;
      // A mode press swallows same-cycle position/increment presses.
      if (press[0]) begin
        mode_q <= next_mode(mode_q);
        pos_q  <= POS_SEC;
        idle_q <= '0;
      end else begin
        case (mode_q)
          MODE_SETUP, MODE_ALARM: begin
            if (press[1]) pos_q  <= next_pos(pos_q);
            if (press[2]) incr_q <= 1'b1;
            if (|press) begin
              idle_q <= '0;
            end else if (idle_q >= IDLE_TIMEOUT - 32'd1) begin
              mode_q <= MODE_CLOCK;
              pos_q  <= POS_SEC;
              idle_q <= '0;
            end else begin
              idle_q <= idle_q + 32'd1;
            end
          end
          MODE_TIMER: begin
            if (press[1]) clr_q <= 1'b1;
            if (press[2]) run_q <= ~run_q;
            idle_q <= '0;
          end
          default: idle_q <= '0;
        endcase
      end
    end
  end

  assign o_mode      = mode_q;
  assign o_position  = pos_q;
  assign o_incr      = incr_q;
  assign o_alarm_en  = alarm_q;
  assign o_timer_run = run_q;
  assign o_timer_clr = clr_q;

endmodule
